// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Mode and time-keeping controller for the mm:ss stopwatch display path.
//   Owns the STOP / RUN / ADJ state machine and the four BCD time digits.
//   It also produces the per-field blank flags used for adjust-mode blinking.
//
// Parameters
//   MAX_MIN  largest minute value (0..99); minutes wrap (or saturate) above it
//   MAX_SEC  largest second value (0..99); seconds wrap above it
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   tick_1hz   1-cycle pulse, count enable while RUN
//   tick_adj   1-cycle pulse (2 Hz), step / blink rate while ADJ
//   pause_p    1-cycle pulse, toggles STOP <-> RUN
//   clr_p      1-cycle pulse, clears time to 00:00 (and done)
//   adj        level, high selects adjust mode
//   sel        level, field adjusted in ADJ: 0 = seconds, 1 = minutes
//   min_l/min_r/sec_l/sec_r  BCD digits, bit [4] always 0
//   running    high while in RUN
//   blank_min  display should blank the minutes digits
//   blank_sec  display should blank the seconds digits
//   done       saturation flag (always 0 unless STOPWATCH_SAT_EN)
//
// Build option
//   STOPWATCH_SAT_EN  defined: RUN saturates at MAX_MIN:MAX_SEC, drops to STOP
//                     and raises done. Undefined: time wraps to 00:00 and the
//                     stopwatch keeps running.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       pause_p,
  input  logic       clr_p,
  input  logic       adj,
  input  logic       sel,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       done
);

  localparam logic [1:0] S_STOP = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ADJ  = 2'd2;

  // Field limits split into BCD tens/units so the wrap test is a digit compare.
  localparam logic [3:0] MIN_L_MAX = 4'(MAX_MIN / 10);
  localparam logic [3:0] MIN_R_MAX = 4'(MAX_MIN % 10);
  localparam logic [3:0] SEC_L_MAX = 4'(MAX_SEC / 10);
  localparam logic [3:0] SEC_R_MAX = 4'(MAX_SEC % 10);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [3:0] r_min_l, r_min_r, r_sec_l, r_sec_r;
  logic       r_blink;
  logic       r_blank_min, r_blank_sec;
  logic       r_running;

  logic [1:0] w_state_nxt;
  logic [3:0] w_min_l_nxt, w_min_r_nxt, w_sec_l_nxt, w_sec_r_nxt;
  logic       w_blink_nxt;
  logic       w_blank_min_nxt, w_blank_sec_nxt;

  logic [7:0] w_min_inc, w_sec_inc;
  logic       w_min_max, w_sec_max;
  logic       w_sat_hit;
  logic       w_pause_ok;

  // One BCD step of a two-digit field, wrapping from the field maximum to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] l, input logic [3:0] r,
                                         input logic [3:0] ml, input logic [3:0] mr);
    logic [7:0] res;
    if (l == ml && r == mr) res = 8'h00;
    else if (r == 4'd9)     res = {l + 4'd1, 4'd0};
    else                    res = {l, r + 4'd1};
    return res;
  endfunction

  assign w_min_inc = bcd_inc(r_min_l, r_min_r, MIN_L_MAX, MIN_R_MAX);
  assign w_sec_inc = bcd_inc(r_sec_l, r_sec_r, SEC_L_MAX, SEC_R_MAX);
  assign w_min_max = (r_min_l == MIN_L_MAX) && (r_min_r == MIN_R_MAX);
  assign w_sec_max = (r_sec_l == SEC_L_MAX) && (r_sec_r == SEC_R_MAX);

  // ---------------------------------------------------------------------------
  // Optional saturation at the top of the range
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_SAT_EN
  logic r_done;

  // A counting tick at full scale; clr_p in the same cycle wins.
  assign w_sat_hit  = (r_state == S_RUN) && tick_1hz && !clr_p && w_min_max && w_sec_max;
  // Once saturated the stopwatch stays parked until cleared.
  assign w_pause_ok = pause_p && !r_done;

  always_ff @(posedge clk) begin
    if (rst)            r_done <= 1'b0;
    else if (clr_p)     r_done <= 1'b0;
    else if (w_sat_hit) r_done <= 1'b1;
  end

  assign done = r_done;
`else
  assign w_sat_hit  = 1'b0;
  assign w_pause_ok = pause_p;
  assign done       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-data logic. Priority inside each state: clr_p > adj > pause_p.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_min_l_nxt     = r_min_l;
    w_min_r_nxt     = r_min_r;
    w_sec_l_nxt     = r_sec_l;
    w_sec_r_nxt     = r_sec_r;
    w_blink_nxt     = r_blink;
    w_blank_min_nxt = r_blank_min;
    w_blank_sec_nxt = r_blank_sec;

    if (clr_p) begin
      w_min_l_nxt = 4'd0;
      w_min_r_nxt = 4'd0;
      w_sec_l_nxt = 4'd0;
      w_sec_r_nxt = 4'd0;
    end

    case (r_state)
      S_STOP: begin
        if (clr_p) begin
          w_state_nxt = S_STOP;
        end else if (adj) begin
          w_state_nxt     = S_ADJ;
          w_blink_nxt     = 1'b0;
          w_blank_min_nxt = 1'b0;
          w_blank_sec_nxt = 1'b0;
        end else if (w_pause_ok) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (clr_p) begin
          w_state_nxt = S_STOP;
        end else begin
          // The tick is counted even when the state leaves RUN on this edge.
          if (tick_1hz && !w_sat_hit) begin
            {w_sec_l_nxt, w_sec_r_nxt} = w_sec_inc;
            if (w_sec_max) {w_min_l_nxt, w_min_r_nxt} = w_min_inc;
          end
          if (adj) begin
            w_state_nxt     = S_ADJ;
            w_blink_nxt     = 1'b0;
            w_blank_min_nxt = 1'b0;
            w_blank_sec_nxt = 1'b0;
          end else if (w_sat_hit || pause_p) begin
            w_state_nxt = S_STOP;
          end
        end
      end

      S_ADJ: begin
        if (clr_p) begin
          // Clear keeps the user in adjust mode; blink phase is untouched.
          w_state_nxt = S_ADJ;
        end else if (!adj) begin
          w_state_nxt     = S_STOP;
          w_blink_nxt     = 1'b0;
          w_blank_min_nxt = 1'b0;
          w_blank_sec_nxt = 1'b0;
        end else if (tick_adj) begin
          // No carry between fields while adjusting.
          if (sel) {w_min_l_nxt, w_min_r_nxt} = w_min_inc;
          else     {w_sec_l_nxt, w_sec_r_nxt} = w_sec_inc;
          // sel is only sampled here, so a field switch shows on the next step.
          w_blink_nxt     = !r_blink;
          w_blank_min_nxt = !r_blink && sel;
          w_blank_sec_nxt = !r_blink && !sel;
        end
      end

      default: begin
        w_state_nxt     = S_STOP;
        w_blink_nxt     = 1'b0;
        w_blank_min_nxt = 1'b0;
        w_blank_sec_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_STOP;
      r_min_l     <= 4'd0;
      r_min_r     <= 4'd0;
      r_sec_l     <= 4'd0;
      r_sec_r     <= 4'd0;
      r_blink     <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_min_l     <= w_min_l_nxt;
      r_min_r     <= w_min_r_nxt;
      r_sec_l     <= w_sec_l_nxt;
      r_sec_r     <= w_sec_r_nxt;
      r_blink     <= w_blink_nxt;
      r_blank_min <= w_blank_min_nxt;
      r_blank_sec <= w_blank_sec_nxt;
      r_running   <= (w_state_nxt == S_RUN);
    end
  end

  assign min_l     = {1'b0, r_min_l};
  assign min_r     = {1'b0, r_min_r};
  assign sec_l     = {1'b0, r_sec_l};
  assign sec_r     = {1'b0, r_sec_r};
  assign running   = r_running;
  assign blank_min = r_blank_min;
  assign blank_sec = r_blank_sec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl: a table of single-cycle vectors followed
//   by hand-written multi-cycle sequences (preload via ADJ, blink, wrap /
//   saturation at 59:59, clear-with-tick).
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, tick_adj = 1'b0, pause_p = 1'b0, clr_p = 1'b0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [4:0] min_l, min_r, sec_l, sec_r;
  logic       running, blank_min, blank_sec, done;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
    .pause_p(pause_p), .clr_p(clr_p), .adj(adj), .sel(sel),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .running(running), .blank_min(blank_min), .blank_sec(blank_sec), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, p, c, a, s, t1, ta;
    int   mm, ss;
    logic run, bm, bs;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  function automatic vec_t mk(input logic r, p, c, a, s, t1, ta,
                              input int mm, ss, input logic run, bm, bs);
    vec_t v;
    v.r = r; v.p = p; v.c = c; v.a = a; v.s = s; v.t1 = t1; v.ta = ta;
    v.mm = mm; v.ss = ss; v.run = run; v.bm = bm; v.bs = bs;
    return v;
  endfunction

  // Drive one cycle of inputs at negedge, sample 1 ns after the next posedge,
  // then drop the pulse inputs (levels adj/sel are held).
  task automatic cyc(input logic r, p, c, a, s, t1, ta);
    @(negedge clk);
    rst = r; pause_p = p; clr_p = c; adj = a; sel = s; tick_1hz = t1; tick_adj = ta;
    @(posedge clk);
    #1;
    rst = 1'b0; pause_p = 1'b0; clr_p = 1'b0; tick_1hz = 1'b0; tick_adj = 1'b0;
  endtask

  task automatic chk(input string nm, input int mm, ss, input logic run, bm, bs, dn);
    logic [23:0] exp_v, act_v;
    exp_v = {5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10), run, bm, bs, dn};
    act_v = {min_l, min_r, sec_l, sec_r, running, blank_min, blank_sec, done};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d%0d:%0d%0d run=%b bmin=%b bsec=%b done=%b, want %02d:%02d run=%b bmin=%b bsec=%b done=%b",
               nm, min_l, min_r, sec_l, sec_r, running, blank_min, blank_sec, done,
               mm, ss, run, bm, bs, dn);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             r  p  c  a  s  t1 ta   mm ss  run bm bs
    vt[nv++] = mk(1, 0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0);  // reset
    vt[nv++] = mk(1, 0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0);
    vt[nv++] = mk(0, 1, 0, 0, 0, 0, 0,   0, 0,  1, 0, 0);  // STOP -> RUN
    vt[nv++] = mk(0, 0, 0, 0, 0, 1, 0,   0, 1,  1, 0, 0);
    vt[nv++] = mk(0, 0, 0, 0, 0, 1, 0,   0, 2,  1, 0, 0);
    vt[nv++] = mk(0, 0, 0, 0, 0, 1, 0,   0, 3,  1, 0, 0);
    vt[nv++] = mk(0, 1, 0, 0, 0, 0, 0,   0, 3,  0, 0, 0);  // RUN -> STOP
    for (int i = 0; i < 5; i++)
      vt[nv++] = mk(0, 0, 0, 0, 0, 1, 0, 0, 3,  0, 0, 0);  // ticks ignored in STOP
    vt[nv++] = mk(0, 0, 0, 0, 0, 1, 1,   0, 3,  0, 0, 0);
    vt[nv++] = mk(0, 1, 0, 0, 0, 0, 0,   0, 3,  1, 0, 0);
    for (int i = 4; i <= 8; i++)
      vt[nv++] = mk(0, 0, 0, 0, 0, 1, 0, 0, i,  1, 0, 0);
    vt[nv++] = mk(0, 1, 0, 0, 0, 1, 0,   0, 9,  0, 0, 0);  // pause+tick in RUN
    vt[nv++] = mk(0, 1, 0, 0, 0, 1, 0,   0, 9,  1, 0, 0);  // pause+tick in STOP
    vt[nv++] = mk(0, 0, 0, 0, 0, 1, 1,   0, 10, 1, 0, 0);  // sec_r carry
    vt[nv++] = mk(0, 0, 1, 0, 0, 1, 0,   0, 0,  0, 0, 0);  // clr beats tick
    vt[nv++] = mk(0, 0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 0);  // enter ADJ
    vt[nv++] = mk(0, 0, 0, 1, 0, 0, 1,   0, 1,  0, 0, 1);
    vt[nv++] = mk(0, 0, 0, 1, 1, 0, 0,   0, 1,  0, 0, 1);  // sel change waits for tick
    vt[nv++] = mk(0, 0, 0, 1, 1, 0, 1,   1, 1,  0, 0, 0);
    vt[nv++] = mk(0, 0, 0, 1, 1, 0, 1,   2, 1,  0, 1, 0);
    vt[nv++] = mk(0, 1, 0, 1, 1, 0, 0,   2, 1,  0, 1, 0);  // pause ignored in ADJ
    vt[nv++] = mk(1, 0, 0, 1, 1, 0, 0,   0, 0,  0, 0, 0);  // rst mid-ADJ
    vt[nv++] = mk(0, 0, 0, 1, 1, 0, 0,   0, 0,  0, 0, 0);
    vt[nv++] = mk(0, 0, 0, 0, 1, 0, 0,   0, 0,  0, 0, 0);  // leave ADJ
    vt[nv++] = mk(0, 1, 0, 0, 0, 0, 0,   0, 0,  1, 0, 0);
    vt[nv++] = mk(0, 0, 1, 0, 0, 0, 0,   0, 0,  0, 0, 0);
    vt[nv++] = mk(0, 0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 0);
    vt[nv++] = mk(0, 0, 0, 1, 0, 0, 1,   0, 1,  0, 0, 1);
    vt[nv++] = mk(0, 0, 1, 1, 0, 0, 0,   0, 0,  0, 0, 1);  // clr stays in ADJ
    vt[nv++] = mk(0, 0, 0, 1, 0, 0, 1,   0, 1,  0, 0, 0);
    vt[nv++] = mk(0, 0, 0, 0, 0, 0, 0,   0, 1,  0, 0, 0);

    for (int i = 0; i < nv; i++) begin
      cyc(vt[i].r, vt[i].p, vt[i].c, vt[i].a, vt[i].s, vt[i].t1, vt[i].ta);
      chk($sformatf("vec%0d", i), vt[i].mm, vt[i].ss, vt[i].run, vt[i].bm, vt[i].bs, 1'b0);
    end

    // Preload 00:59 through ADJ, then roll into 01:00 while running.
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 59; k++) cyc(0, 0, 0, 1, 0, 0, 1);
    chk("preload_0059", 0, 59, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("exit_adj", 0, 59, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("carry_0100", 1, 0, 1, 0, 0, 0);

    // Minutes wrap in ADJ with no carry and blink toggling on every step.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) cyc(0, 0, 0, 1, 0, 0, 1);
    chk("adj_sec7", 0, 7, 0, 0, 1, 0);
    for (int k = 8; k <= 67; k++) begin
      cyc(0, 0, 0, 1, 1, 0, 1);
      chk($sformatf("adj_min_k%0d", k), (k - 7) % 60, 7, 0, (k % 2) == 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("adj_exit_blanks", 0, 7, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("exit_was_stop", 0, 7, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Full-scale tick at 59:59.
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("adj_clr", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 59; k++) cyc(0, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 59; k++) cyc(0, 0, 0, 1, 1, 0, 1);
    chk("preload_5959", 59, 59, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("run_5959", 59, 59, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
`ifdef STOPWATCH_SAT_EN
    chk("sat_hold", 59, 59, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("sat_pause_ignored", 59, 59, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("sat_clr", 0, 0, 0, 0, 0, 0);
`else
    chk("wrap_0000", 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("wrap_keeps_running", 0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("wrap_clr", 0, 0, 0, 0, 0, 0);
`endif

    // Clear with a simultaneous count tick while running at 12:34.
    cyc(0, 0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 1, 0, 1);
    for (int k = 0; k < 34; k++) cyc(0, 0, 0, 1, 0, 0, 1);
    chk("preload_1234", 12, 34, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("run_1234", 12, 34, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("clr_tick_1234", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode and time-keeping controller for the mm:ss stopwatch display path. It owns the STOP/RUN/ADJ state machine and the four BCD time digits. It feeds min_l/min_r/sec_l/sec_r to the display block and emits per-field blank flags for adjust-mode blinking. All button inputs arrive as debounced single-cycle pulses or levels; time bases arrive as single-cycle tick pulses from the clock divider.

Parameters:
MAX_MIN, 59, largest minute value; minutes field wraps or saturates above this.
MAX_SEC, 59, largest second value; seconds field wraps above this.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tick_1hz  input  1  one-cycle pulse; count enable in RUN
tick_adj  input  1  one-cycle pulse (2 Hz); adjust-step and blink rate in ADJ
pause_p  input  1  one-cycle pulse; toggles STOP/RUN
clr_p  input  1  one-cycle pulse; clears time to 00:00
adj  input  1  level; high selects adjust mode
sel  input  1  level; field selected in ADJ: 0 = seconds, 1 = minutes
min_l  output  5  minutes tens digit, 0-5
min_r  output  5  minutes units digit, 0-9
sec_l  output  5  seconds tens digit, 0-5
sec_r  output  5  seconds units digit, 0-9
running  output  1  high while state is RUN
blank_min  output  1  high = display should blank minutes digits
blank_sec  output  1  high = display should blank seconds digits
done  output  1  saturation flag (see Optional Feature)

Behaviour:
- All outputs are registered and update on the clk edge after the causing input. Digit bit [4] is always 0.
- Reset (rst=1 at posedge): state=STOP, all digits 0, running=0, blink=0, blank_min=0, blank_sec=0, done=0. rst overrides every other input, including mid-ADJ and mid-RUN.
- States: STOP, RUN, ADJ. Encoding is free.
- Transitions are evaluated on the current state, with priority rst > clr_p > adj > pause_p:
  - STOP: adj=1 -> ADJ; else pause_p -> RUN.
  - RUN: adj=1 -> ADJ; else pause_p -> STOP.
  - ADJ: adj=0 -> STOP. pause_p is ignored.
- clr_p: all digits -> 0 and done -> 0. From STOP or RUN, next state is STOP. From ADJ, state stays ADJ. The clr_p cycle suppresses any tick increment in that cycle.
- Counting happens in RUN only, on tick_1hz, and is BCD:
  - sec_r increments.
  - At sec_r=9: sec_r -> 0 and sec_l increments.
  - At seconds = MAX_SEC: seconds -> 00 and minutes increment with the same BCD rules.
  - At minutes = MAX_MIN with a seconds carry: minutes wrap to 00, so the time wraps to 00:00 (default build).
- tick_1hz together with pause_p while in RUN: the increment is applied and the state becomes STOP in the same edge. tick_1hz together with pause_p while in STOP: no increment; state -> RUN.
- tick_1hz is ignored in STOP and ADJ.
- ADJ stepping, on each tick_adj:
  - The selected field increments by 1 in BCD, wrapping from MAX to 00.
  - There is no carry into the other field.
  - The internal blink bit toggles.
- ADJ blanking: blank_sec = blink & ~sel; blank_min = blink & sel.
- A change of sel takes effect on the next tick_adj; blink is not reset by sel.
- Entering ADJ clears blink to 0. Leaving ADJ clears blink and both blank flags to 0 on the exit edge.
- Simultaneous tick_1hz and tick_adj: only the tick relevant to the current state acts.

Optional Feature:
Macro STOPWATCH_SAT_EN.
- Defined: in RUN, a tick_1hz at MAX_MIN:MAX_SEC holds 59:59, moves state to STOP and sets done=1. done stays set until rst or clr_p. pause_p while done=1 is ignored, so the stopwatch cannot re-enter RUN until it is cleared. ADJ increments still wrap and do not set done.
- Undefined: time wraps to 00:00 and RUN continues. done is tied to 0.

Test Plan:
1. rst=1 for 2 cycles, then pause_p, then 3 tick_1hz -> running=1, digits 0,0,0,3; after a further pause_p, running=0 and 5 more ticks leave 00:03.
2. Preload 00:59 via ADJ (sel=0, 59 tick_adj). Exit ADJ, pause_p, 1 tick_1hz -> digits 0,1,0,0.
3. ADJ sel=1, 60 tick_adj from 00 -> minutes back to 00 and seconds unchanged. Check blank_min toggles each tick_adj and blank_sec=0 throughout; drop adj -> both blanks 0, state STOP.
4. At 59:59 in RUN, 1 tick_1hz:
   - default build -> 00:00, running=1, done=0.
   - STOPWATCH_SAT_EN -> 59:59, running=0, done=1; pause_p ignored; clr_p -> 00:00, done=0.
5. RUN at 12:34 with clr_p and tick_1hz in the same cycle -> 00:00, running=0. Then rst during ADJ -> STOP, digits 0, blanks 0.
6. RUN with pause_p and tick_1hz in the same cycle at 00:08 -> 00:09, running=0.
